// File: rtl/instruction_fetch.sv
// Purpose: fetch stage; owns the PC, drives the ROM address and registers the returned instruction for decode.
// Latency: one edge from oAddress==A to the instruction at A on oInstruction/oPC; one instruction per cycle in RUN.
// Backpressure: iStall holds every register (including a NOP countdown); a branch overrides a stall; iEnable=0 overrides all.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    INSN_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [3:0]            NOP_OPCODE = 4'd0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iEnable,
  input  logic                  iStall,
  input  logic                  iBranchTaken,
  input  logic [ADDR_WIDTH-1:0] iBranchTarget,
  output logic [ADDR_WIDTH-1:0] oAddress,
  input  logic [INSN_WIDTH-1:0] iInstruction,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0] oPC,
  output logic                  oValid
);

  // Immediate field below the 4-bit opcode doubles as the NOP wait count.
  localparam int IMM_WIDTH = INSN_WIDTH - 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DELAY = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
  logic [INSN_WIDTH-1:0]   insn_q, insn_nxt;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_q_nxt;
  logic                    valid_q, valid_nxt;
  logic [IMM_WIDTH-1:0]    cnt, cnt_nxt;

  logic [3:0]              fetch_opcode;
  logic [IMM_WIDTH-1:0]    fetch_imm;
  logic                    fetch_is_delay;

  assign fetch_opcode   = iInstruction[INSN_WIDTH-1 -: 4];
  assign fetch_imm      = iInstruction[IMM_WIDTH-1:0];
  // A NOP with zero immediate behaves as an ordinary single-cycle instruction.
  assign fetch_is_delay = (fetch_opcode == NOP_OPCODE) && (fetch_imm != '0);

  // Next-state and next-register computation; everything holds by default.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    insn_nxt  = insn_q;
    pc_q_nxt  = pc_q;
    valid_nxt = valid_q;
    cnt_nxt   = cnt;

    if (!iEnable) begin
      // Disable beats branch and stall; the fetch context is frozen.
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Entry edge does no fetch; the first fetch happens on the next edge.
          state_nxt = RUN;
          valid_nxt = 1'b0;
        end
        RUN, DELAY: begin
          if (iBranchTaken) begin
            // Redirect: discard this cycle's ROM data and abort any wait.
            pc_nxt    = iBranchTarget;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else if (iStall) begin
            // Hold everything, including a pending countdown.
            state_nxt = state;
          end else if (state == RUN) begin
            insn_nxt  = iInstruction;
            pc_q_nxt  = pc;
            valid_nxt = 1'b1;
            pc_nxt    = pc + ADDR_WIDTH'(1);
            if (fetch_is_delay) begin
              cnt_nxt   = fetch_imm;
              state_nxt = DELAY;
            end
          end else begin
            // Countdown: N edges of oValid=0 after a NOP with immediate N.
            valid_nxt = 1'b0;
            cnt_nxt   = cnt - IMM_WIDTH'(1);
            if (cnt == IMM_WIDTH'(1)) begin
              state_nxt = RUN;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      pc      <= RESET_ADDR;
      insn_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      insn_q  <= insn_nxt;
      pc_q    <= pc_q_nxt;
      valid_q <= valid_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // ROM address comes straight from the PC register, never from inputs.
  assign oAddress     = pc;
  assign oInstruction = insn_q;
  assign oPC          = pc_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        Clock;
  logic        Reset;
  logic        iEnable;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;

  logic [27:0] rom [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
    logic [27:0] exp_insn;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch #(
    .ADDR_WIDTH(16),
    .INSN_WIDTH(28),
    .RESET_ADDR(16'd0),
    .NOP_OPCODE(4'd0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iEnable(iEnable),
    .iStall(iStall),
    .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oAddress(oAddress),
    .iInstruction(iInstruction),
    .oInstruction(oInstruction),
    .oPC(oPC),
    .oValid(oValid)
  );

  // Combinational ROM.
  assign iInstruction = rom[oAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic st, input logic br, input logic [15:0] tgt,
                     input logic v, input logic [15:0] pc, input logic [15:0] addr, input logic [27:0] insn);
    vec_t r;
    r.en = en; r.stall = st; r.br = br; r.tgt = tgt;
    r.exp_valid = v; r.exp_pc = pc; r.exp_addr = addr; r.exp_insn = insn;
    vecs.push_back(r);
  endtask

  initial begin
    // ROM image: filler words use opcode 7 (never a NOP), then the test program.
    for (int i = 0; i < 65536; i++) rom[i] = 28'h7000000 | 28'(i);
    rom[16'h0000] = 28'h1020001;  // STO R2,1
    rom[16'h0001] = 28'h1010002;  // STO R1,2
    rom[16'h0002] = 28'h5710102;  // IMUL R7,R1,R2
    rom[16'h0003] = 28'h0000004;  // NOP 4
    rom[16'h0004] = 28'h1030004;
    rom[16'h0005] = 28'h0000000;  // NOP 0
    rom[16'h0006] = 28'h1040006;
    rom[16'h0008] = 28'h0000002;  // NOP 2
    rom[16'h0010] = 28'h2000010;
    rom[16'h0011] = 28'h2000011;
    rom[16'hFFFF] = 28'h3FFFF00;

    //   en st br tgt        v  pc       addr     insn
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 28'h0);        // IDLE->RUN, no fetch
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 28'h1020001);
    add(1, 0, 0, 16'h0000, 1, 16'h0001, 16'h0002, 28'h1010002);
    add(1, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 28'h1010002);  // stall x3
    add(1, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 28'h1010002);
    add(1, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 28'h1010002);
    add(1, 0, 0, 16'h0000, 1, 16'h0002, 16'h0003, 28'h5710102);
    add(1, 0, 0, 16'h0000, 1, 16'h0003, 16'h0004, 28'h0000004);  // NOP 4
    add(1, 0, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);        // 4->3
    add(1, 0, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);        // 3->2
    add(1, 1, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);        // stall in DELAY x3
    add(1, 1, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);
    add(1, 1, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);
    add(1, 0, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);        // 2->1
    add(1, 0, 0, 16'h0000, 0, 16'h0003, 16'h0004, 28'h0);        // 1->0, back to RUN
    add(1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0005, 28'h1030004);
    add(1, 0, 0, 16'h0000, 1, 16'h0005, 16'h0006, 28'h0000000);  // NOP 0
    add(1, 0, 0, 16'h0000, 1, 16'h0006, 16'h0007, 28'h1040006);  // no gap
    add(1, 0, 1, 16'h0010, 0, 16'h0006, 16'h0010, 28'h0);        // branch bubble
    add(1, 0, 0, 16'h0000, 1, 16'h0010, 16'h0011, 28'h2000010);
    add(1, 1, 1, 16'h0010, 0, 16'h0010, 16'h0010, 28'h0);        // branch + stall
    add(1, 0, 0, 16'h0000, 1, 16'h0010, 16'h0011, 28'h2000010);
    add(1, 0, 1, 16'h0008, 0, 16'h0010, 16'h0008, 28'h0);
    add(1, 0, 0, 16'h0000, 1, 16'h0008, 16'h0009, 28'h0000002);  // NOP 2
    add(1, 0, 0, 16'h0000, 0, 16'h0008, 16'h0009, 28'h0);        // 2->1
    add(1, 0, 1, 16'h0011, 0, 16'h0008, 16'h0011, 28'h0);        // branch aborts wait
    add(1, 0, 0, 16'h0000, 1, 16'h0011, 16'h0012, 28'h2000011);
    add(1, 0, 1, 16'hFFFF, 0, 16'h0011, 16'hFFFF, 28'h0);
    add(1, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 28'h3FFFF00);  // wrap
    add(1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 28'h1020001);
    add(0, 0, 1, 16'h0010, 0, 16'h0000, 16'h0001, 28'h0);        // disable beats branch
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0001, 28'h0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0001, 28'h0);        // IDLE->RUN
    add(1, 0, 0, 16'h0000, 1, 16'h0001, 16'h0002, 28'h1010002);

    iEnable = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0000;
    Reset = 1'b0;
    #3;
    check("rst_valid", {31'd0, oValid}, 32'd0);
    check("rst_addr",  {16'd0, oAddress}, 32'h0);
    check("rst_insn",  {4'd0, oInstruction}, 32'h0);
    check("rst_pc",    {16'd0, oPC}, 32'h0);
    #9 Reset = 1'b1;   // released between edges
    @(posedge Clock); #1;
    check("idle_valid", {31'd0, oValid}, 32'd0);
    check("idle_addr",  {16'd0, oAddress}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      iEnable = vecs[i].en; iStall = vecs[i].stall;
      iBranchTaken = vecs[i].br; iBranchTarget = vecs[i].tgt;
      @(posedge Clock); #1;
      check($sformatf("v%0d_valid", i), {31'd0, oValid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_addr", i), {16'd0, oAddress}, {16'd0, vecs[i].exp_addr});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i), {16'd0, oPC}, {16'd0, vecs[i].exp_pc});
        check($sformatf("v%0d_insn", i), {4'd0, oInstruction}, {4'd0, vecs[i].exp_insn});
      end
    end
    iStall = 1'b0; iBranchTaken = 1'b0;

    // Asynchronous reset mid-run, between edges.
    #2 Reset = 1'b0;
    #1;
    check("async_valid", {31'd0, oValid}, 32'd0);
    check("async_addr",  {16'd0, oAddress}, 32'h0);
    check("async_insn",  {4'd0, oInstruction}, 32'h0);
    check("async_pc",    {16'd0, oPC}, 32'h0);
    iEnable = 1'b0;
    #2 Reset = 1'b1;
    @(posedge Clock); #1;
    check("post_rst_valid", {31'd0, oValid}, 32'd0);
    iEnable = 1'b1;
    @(posedge Clock); #1;
    check("en_edge1_valid", {31'd0, oValid}, 32'd0);
    check("en_edge1_addr",  {16'd0, oAddress}, 32'h0);
    @(posedge Clock); #1;
    check("en_edge2_valid", {31'd0, oValid}, 32'd1);
    check("en_edge2_pc",    {16'd0, oPC}, 32'h0);
    check("en_edge2_insn",  {4'd0, oInstruction}, 32'h1020001);
    check("en_edge2_addr",  {16'd0, oAddress}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
